spi_reg_bank: RTL and testbench

- Downstream consumer of the serial-register front end.
- Takes the parallel address/data word and the end-of-transaction strobe, both in the FX2_CLK domain.
- Decodes, validates and commits write transactions into eight 8-bit general-purpose registers. Those registers drive board logic (LEDs, control bits) and loop back as the front end's readback inputs.
- Counts read transactions and protocol errors for diagnostics.

---
 rtl/spi_reg_bank.sv | 180 ++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: validates and commits serial-front-end writes into eight
// GP registers; counts reads and rejected transactions.
//
// Ports:
//   FX2_CLK         sole clock
//   reset           synchronous active-high reset
//   saddr[6:0]      bit5 = read flag, bits[4:0] = register address,
//                   bit6 ignored
//   sdata[7:0]      write data
//   sstrobe         one-cycle end-of-transaction pulse
//   GPReg0..GPReg7  register contents
//   wr_pulse        one-cycle commit pulse
//   wr_index        index of the committed register, held between pulses
//   rd_count        saturating read-transaction count
//   err_count       saturating rejected-transaction count
//   busy            FSM not in IDLE
//
// Build option SHADOW_COMMIT_EN: writes to addresses 1..8 land in shadow
// registers; a write to address 9 copies all shadows to GPReg0..7 at once.
module spi_reg_bank #(
    parameter logic [7:0] REG_RESET = 8'h00,
    parameter int         ERR_CNT_W = 8
) (
    input  logic                 FX2_CLK,
    input  logic                 reset,
    input  logic [6:0]           saddr,
    input  logic [7:0]           sdata,
    input  logic                 sstrobe,
    output logic [7:0]           GPReg0,
    output logic [7:0]           GPReg1,
    output logic [7:0]           GPReg2,
    output logic [7:0]           GPReg3,
    output logic [7:0]           GPReg4,
    output logic [7:0]           GPReg5,
    output logic [7:0]           GPReg6,
    output logic [7:0]           GPReg7,
    output logic                 wr_pulse,
    output logic [2:0]           wr_index,
    output logic [ERR_CNT_W-1:0] rd_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        VALIDATE,
        COMMIT
    } state_t;

    state_t     state;
    logic       pending;
    logic [5:0] cap_addr;
    logic [7:0] cap_data;
    logic [7:0] gp [0:7];
`ifdef SHADOW_COMMIT_EN
    logic [7:0] shadow [0:7];
`endif

    // saddr[6] carries no meaning for this block
    logic unused_saddr6;
    assign unused_saddr6 = saddr[6];

    logic       mismatch;
    logic       is_read;
    logic       addr_ok;
    logic       val_err;
    logic       overflow;
    logic       rd_inc;
    logic [1:0] err_inc;
    logic [2:0] idx;

    assign mismatch = (saddr[5:0] != cap_addr) || (sdata != cap_data);
    assign is_read  = cap_addr[5];
    // Addresses are 1-based: 1..8 map onto registers 0..7
    assign idx      = cap_addr[2:0] - 3'd1;

`ifdef SHADOW_COMMIT_EN
    assign addr_ok = (cap_addr[4:0] != 5'd0) && (cap_addr[4:0] <= 5'd9);
`else
    assign addr_ok = (cap_addr[4:0] != 5'd0) && (cap_addr[4:0] <= 5'd8);
`endif

    assign val_err  = (state == VALIDATE) &&
                      (mismatch || (!is_read && !addr_ok));
    assign rd_inc   = (state == VALIDATE) && !mismatch && is_read;
    // Pending is only one deep; a further strobe is dropped
    assign overflow = sstrobe && (state != IDLE) && pending;
    // A validation error and an overflow in one cycle add two
    assign err_inc  = {1'b0, val_err} + {1'b0, overflow};

    function automatic logic [ERR_CNT_W-1:0] sat_add(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [1:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + (ERR_CNT_W+1)'(inc);
        if (sum[ERR_CNT_W])
            return '1;
        return sum[ERR_CNT_W-1:0];
    endfunction

    always_ff @(posedge FX2_CLK) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
            rd_count  <= '0;
            err_count <= '0;
            for (int i = 0; i < 8; i++) begin
                gp[i] <= REG_RESET;
`ifdef SHADOW_COMMIT_EN
                shadow[i] <= REG_RESET;
`endif
            end
        end else begin
            wr_pulse  <= 1'b0;
            err_count <= sat_add(err_count, err_inc);
            rd_count  <= sat_add(rd_count, {1'b0, rd_inc});

            if (state == IDLE) begin
                // Servicing the pending request while a new strobe
                // arrives queues the new one behind it
                pending <= pending && sstrobe;
            end else if (sstrobe && !pending) begin
                pending <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (sstrobe || pending)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    cap_addr <= saddr[5:0];
                    cap_data <= sdata;
                    state    <= VALIDATE;
                end
                VALIDATE: begin
                    if (!mismatch && !is_read && addr_ok)
                        state <= COMMIT;
                    else
                        state <= IDLE;
                end
                COMMIT: begin
                    wr_pulse <= 1'b1;
                    state    <= IDLE;
`ifdef SHADOW_COMMIT_EN
                    if (cap_addr[4:0] == 5'd9) begin
                        for (int i = 0; i < 8; i++)
                            gp[i] <= shadow[i];
                        wr_index <= 3'd0;
                    end else begin
                        shadow[idx] <= cap_data;
                        wr_index    <= idx;
                    end
`else
                    gp[idx]  <= cap_data;
                    wr_index <= idx;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign GPReg0 = gp[0];
    assign GPReg1 = gp[1];
    assign GPReg2 = gp[2];
    assign GPReg3 = gp[3];
    assign GPReg4 = gp[4];
    assign GPReg5 = gp[5];
    assign GPReg6 = gp[6];
    assign GPReg7 = gp[7];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: commit latency, reads, rejects,
// pending/overflow, counter saturation and reset during COMMIT.
module tb_spi_reg_bank;

    logic       FX2_CLK = 1'b0;
    logic       reset;
    logic [6:0] saddr;
    logic [7:0] sdata;
    logic       sstrobe;
    logic [7:0] GPReg0, GPReg1, GPReg2, GPReg3;
    logic [7:0] GPReg4, GPReg5, GPReg6, GPReg7;
    logic       wr_pulse;
    logic [2:0] wr_index;
    logic [7:0] rd_count;
    logic [7:0] err_count;
    logic       busy;

    int total = 0;
    int bad   = 0;

    spi_reg_bank #(
        .REG_RESET(8'h00),
        .ERR_CNT_W(8)
    ) dut (
        .FX2_CLK  (FX2_CLK),
        .reset    (reset),
        .saddr    (saddr),
        .sdata    (sdata),
        .sstrobe  (sstrobe),
        .GPReg0   (GPReg0),
        .GPReg1   (GPReg1),
        .GPReg2   (GPReg2),
        .GPReg3   (GPReg3),
        .GPReg4   (GPReg4),
        .GPReg5   (GPReg5),
        .GPReg6   (GPReg6),
        .GPReg7   (GPReg7),
        .wr_pulse (wr_pulse),
        .wr_index (wr_index),
        .rd_count (rd_count),
        .err_count(err_count),
        .busy     (busy)
    );

    always #5 FX2_CLK = ~FX2_CLK;

    task automatic step();
        @(posedge FX2_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction: strobe, capture, validate, commit edges
    task automatic txn(input logic [6:0] a, input logic [7:0] d);
        saddr   = a;
        sdata   = d;
        sstrobe = 1'b1;
        step();
        sstrobe = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        reset   = 1'b1;
        saddr   = '0;
        sdata   = '0;
        sstrobe = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_gp0", {24'd0, GPReg0}, 32'h00);
        chk("rst_gp7", {24'd0, GPReg7}, 32'h00);
        chk("rst_wrp", {31'd0, wr_pulse}, 32'd0);
        chk("rst_wri", {29'd0, wr_index}, 32'd0);
        chk("rst_rdc", {24'd0, rd_count}, 32'd0);
        chk("rst_erc", {24'd0, err_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Write addr 3 -> GPReg2, visible 3 edges after the strobe edge
        saddr   = 7'h03;
        sdata   = 8'hA5;
        sstrobe = 1'b1;
        step();
        sstrobe = 1'b0;
        chk("w3_busy", {31'd0, busy}, 32'd1);
        step();
        step();
        chk("w3_early_gp2", {24'd0, GPReg2}, 32'h00);
        chk("w3_early_wrp", {31'd0, wr_pulse}, 32'd0);
        step();
        chk("w3_gp2", {24'd0, GPReg2}, 32'hA5);
        chk("w3_wrp", {31'd0, wr_pulse}, 32'd1);
        chk("w3_wri", {29'd0, wr_index}, 32'd2);
        chk("w3_gp1", {24'd0, GPReg1}, 32'h00);
        chk("w3_gp3", {24'd0, GPReg3}, 32'h00);
        step();
        chk("w3_wrp_off", {31'd0, wr_pulse}, 32'd0);
        chk("w3_wri_hold", {29'd0, wr_index}, 32'd2);

        // Read of addr 1
        txn(7'h21, 8'h00);
        chk("rd_wrp", {31'd0, wr_pulse}, 32'd0);
        chk("rd_cnt", {24'd0, rd_count}, 32'd1);
        chk("rd_gp0", {24'd0, GPReg0}, 32'h00);
        chk("rd_gp2", {24'd0, GPReg2}, 32'hA5);

        // Invalid addresses 0 and 10
        step();
        txn(7'h00, 8'h55);
        step();
        txn(7'h0A, 8'h66);
        step();
        chk("inv_err", {24'd0, err_count}, 32'd2);
        chk("inv_gp0", {24'd0, GPReg0}, 32'h00);

        // Data changes between CAPTURE and VALIDATE
        saddr   = 7'h01;
        sdata   = 8'h11;
        sstrobe = 1'b1;
        step();
        sstrobe = 1'b0;
        step();
        sdata = 8'h22;
        step();
        step();
        chk("mm_err", {24'd0, err_count}, 32'd3);
        chk("mm_wrp", {31'd0, wr_pulse}, 32'd0);
        chk("mm_gp0", {24'd0, GPReg0}, 32'h00);
        step();

        // Three back-to-back strobes: first serviced, second pending,
        // third overflows. The front end holds each word while sampled.
        saddr   = 7'h01;
        sdata   = 8'h31;
        sstrobe = 1'b1;
        step();
        step();
        chk("tri_pend_err", {24'd0, err_count}, 32'd3);
        step();
        sstrobe = 1'b0;
        chk("tri_ovf_err", {24'd0, err_count}, 32'd4);
        step();
        chk("tri_gp0", {24'd0, GPReg0}, 32'h31);
        chk("tri_wri0", {29'd0, wr_index}, 32'd0);
        saddr = 7'h02;
        sdata = 8'h32;
        step();
        chk("tri_busy", {31'd0, busy}, 32'd1);
        step();
        step();
        step();
        chk("tri_gp1", {24'd0, GPReg1}, 32'h32);
        chk("tri_wrp1", {31'd0, wr_pulse}, 32'd1);
        chk("tri_wri1", {29'd0, wr_index}, 32'd1);
        chk("tri_gp2", {24'd0, GPReg2}, 32'hA5);
        chk("tri_err", {24'd0, err_count}, 32'd4);
        step();
        chk("tri_idle", {31'd0, busy}, 32'd0);

        // Saturate err_count with invalid writes
        for (int i = 0; i < 255; i++) begin
            txn(7'h00, 8'h00);
            step();
        end
        chk("sat_err", {24'd0, err_count}, 32'hFF);
        txn(7'h1F, 8'h00);
        step();
        chk("sat_hold", {24'd0, err_count}, 32'hFF);
        chk("sat_rd", {24'd0, rd_count}, 32'd1);

        // Reset asserted in the COMMIT cycle
        saddr   = 7'h04;
        sdata   = 8'h77;
        sstrobe = 1'b1;
        step();
        sstrobe = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rc_gp3", {24'd0, GPReg3}, 32'h00);
        chk("rc_gp2", {24'd0, GPReg2}, 32'h00);
        chk("rc_wrp", {31'd0, wr_pulse}, 32'd0);
        chk("rc_err", {24'd0, err_count}, 32'd0);
        chk("rc_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();
        chk("rc_after_wrp", {31'd0, wr_pulse}, 32'd0);

`ifdef SHADOW_COMMIT_EN
        txn(7'h01, 8'h5A);
        chk("sh_wrp", {31'd0, wr_pulse}, 32'd1);
        chk("sh_wri", {29'd0, wr_index}, 32'd0);
        chk("sh_gp0_old", {24'd0, GPReg0}, 32'h00);
        step();
        txn(7'h09, 8'hEE);
        chk("sh_gp0_new", {24'd0, GPReg0}, 32'h5A);
        chk("sh_wri9", {29'd0, wr_index}, 32'd0);
        chk("sh_gp1", {24'd0, GPReg1}, 32'h00);
        step();
`else
        // Highest address, with the ignored bit6 set
        txn(7'h48, 8'hC3);
        chk("a8_gp7", {24'd0, GPReg7}, 32'hC3);
        chk("a8_wri", {29'd0, wr_index}, 32'd7);
        step();
        // Address 9 is a reject in the direct-commit build
        txn(7'h09, 8'hEE);
        step();
        chk("a9_err", {24'd0, err_count}, 32'd1);
        chk("a9_gp0", {24'd0, GPReg0}, 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
